yin_frame_feeder: RTL and testbench

- Front end of the pitch-estimation path: accepts a streaming sample input and builds the flattened analysis window consumed by the min-tau estimator.
- Restarts the estimator on each new frame, waits for its ready flag, and publishes the resulting tau as a one-cycle-valid result.
- Consecutive frames overlap and advance by HOP samples.

---
 rtl/yin_frame_feeder_if.sv | 46 ++++
 rtl/yin_frame_feeder.sv | 177 +++++++++++++++++
 tb/tb_yin_frame_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yin_frame_feeder_if.sv
// yin_frame_feeder_if
//   Bundles the sample stream, estimator handshake and pitch result of the
//   YIN frame feeder. clk/reset are not part of the bundle.
//   Parameters: DATA_WIDTH (bits per sample), WINDOW_LEN (samples per frame).
//   Modports:
//     master - upstream/estimator side: drives sample_in, sample_valid,
//              est_ready, est_min_tau; observes everything else.
//     slave  - the feeder itself.
//   With YIN_FEEDER_DROP_EN defined the bundle also carries drop_count.
interface yin_frame_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WINDOW_LEN = 296
);
  logic [DATA_WIDTH-1:0]            sample_in;
  logic                             sample_valid;
  logic                             sample_ready;
  logic [WINDOW_LEN*DATA_WIDTH-1:0] window;
  logic                             est_reset;
  logic                             est_ready;
  logic [7:0]                       est_min_tau;
  logic [7:0]                       pitch_tau;
  logic                             pitch_valid;
  logic                             timeout;
  logic [15:0]                      frame_count;
`ifdef YIN_FEEDER_DROP_EN
  logic [15:0]                      drop_count;
`endif

  modport master (
    output sample_in, sample_valid, est_ready, est_min_tau,
`ifdef YIN_FEEDER_DROP_EN
    input  drop_count,
`endif
    input  sample_ready, window, est_reset, pitch_tau, pitch_valid, timeout,
           frame_count
  );

  modport slave (
    input  sample_in, sample_valid, est_ready, est_min_tau,
`ifdef YIN_FEEDER_DROP_EN
    output drop_count,
`endif
    output sample_ready, window, est_reset, pitch_tau, pitch_valid, timeout,
           frame_count
  );
endinterface

// File: rtl/yin_frame_feeder.sv
// yin_frame_feeder
//   Front end of the pitch-estimation path. Streams samples into a shifting
//   analysis window of N = 2**WINDOW_SIZE_BITS + MAX_TAU slots (slot 0 oldest),
//   restarts the min-tau estimator once per frame, waits for its ready flag
//   (or a timeout) and publishes tau as a one-cycle pulse. After the initial
//   N-sample fill, each further frame needs HOP new samples.
//   Ports:
//     clk    - clock
//     reset  - asynchronous, active-low reset
//     bus    - yin_frame_feeder_if.slave: sample stream (sample_in/valid/ready),
//              window, estimator handshake (est_reset/est_ready/est_min_tau),
//              result (pitch_tau/pitch_valid/timeout/frame_count)
//   Build option YIN_FEEDER_DROP_EN: sample_ready stays high outside reset;
//   samples arriving while the window is frozen are discarded and counted in
//   bus.drop_count (saturating).
module yin_frame_feeder #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned WINDOW_SIZE_BITS = 8,
  parameter int unsigned MAX_TAU          = 40,
  parameter int unsigned HOP              = 64,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input logic              clk,
  input logic              reset,
  yin_frame_feeder_if.slave bus
);

  localparam int unsigned N      = (2 ** WINDOW_SIZE_BITS) + MAX_TAU;
  localparam int unsigned WIN_W  = N * DATA_WIDTH;
  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    FILL,
    KICK,
    WAIT,
    PUBLISH
  } state_e;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [7:0]         pitch_tau_q, pitch_tau_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        frame_count_q, frame_count_d;
`ifdef YIN_FEEDER_DROP_EN
  logic [15:0]        drop_count_q, drop_count_d;
`endif

  logic sample_ready;
  logic est_reset;
  logic pitch_valid;
  logic accept;
  logic to_expired;

  assign accept     = bus.sample_valid & sample_ready;
  assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (accept && (fill_cnt_q == FILL_W'(1))) state_d = KICK;
      KICK:    state_d = WAIT;
      WAIT:    if (bus.est_ready || to_expired) state_d = PUBLISH;
      PUBLISH: state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output decode; sample_ready is gated by reset so it reads 0 while held
  always_comb begin
    sample_ready = 1'b0;
    est_reset    = 1'b1;
    pitch_valid  = 1'b0;
    unique case (state_q)
      FILL:    sample_ready = reset;
      KICK:    ;
      WAIT:    est_reset = 1'b0;
      PUBLISH: pitch_valid = 1'b1;
      default: ;
    endcase
`ifdef YIN_FEEDER_DROP_EN
    sample_ready = reset;
`endif
  end

  // Datapath next values
  always_comb begin
    fill_cnt_d    = fill_cnt_q;
    to_cnt_d      = to_cnt_q;
    window_d      = window_q;
    pitch_tau_d   = pitch_tau_q;
    timeout_d     = timeout_q;
    frame_count_d = frame_count_q;
`ifdef YIN_FEEDER_DROP_EN
    drop_count_d  = drop_count_q;
    if (accept && (state_q != FILL) && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
`endif

    if ((state_q == FILL) && accept) begin
      window_d   = {bus.sample_in, window_q[WIN_W-1:DATA_WIDTH]};
      fill_cnt_d = fill_cnt_q - FILL_W'(1);
    end

    if (state_q == KICK) begin
      to_cnt_d = '0;
    end

    // Result registers (and frame_count) load on the WAIT->PUBLISH edge so
    // the new values are already visible during the pitch_valid cycle.
    if (state_q == WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (bus.est_ready) begin
        pitch_tau_d   = bus.est_min_tau;
        timeout_d     = 1'b0;
        frame_count_d = frame_count_q + 16'd1;
      end else if (to_expired) begin
        pitch_tau_d   = '0;
        timeout_d     = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
      end
    end

    if (state_q == PUBLISH) begin
      fill_cnt_d = FILL_W'(HOP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_q    <= FILL_W'(N);
      to_cnt_q      <= '0;
      window_q      <= '0;
      pitch_tau_q   <= '0;
      timeout_q     <= 1'b0;
      frame_count_q <= '0;
`ifdef YIN_FEEDER_DROP_EN
      drop_count_q  <= '0;
`endif
    end else begin
      fill_cnt_q    <= fill_cnt_d;
      to_cnt_q      <= to_cnt_d;
      window_q      <= window_d;
      pitch_tau_q   <= pitch_tau_d;
      timeout_q     <= timeout_d;
      frame_count_q <= frame_count_d;
`ifdef YIN_FEEDER_DROP_EN
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  assign bus.sample_ready = sample_ready;
  assign bus.est_reset    = est_reset;
  assign bus.pitch_valid  = pitch_valid;
  assign bus.window       = window_q;
  assign bus.pitch_tau    = pitch_tau_q;
  assign bus.timeout      = timeout_q;
  assign bus.frame_count  = frame_count_q;
`ifdef YIN_FEEDER_DROP_EN
  assign bus.drop_count   = drop_count_q;
`endif

endmodule

// File: tb/tb_yin_frame_feeder.sv
module tb_yin_frame_feeder;
  localparam int unsigned DW       = 8;
  localparam int unsigned N        = 296;
  localparam int unsigned HOP      = 64;
  localparam int unsigned TO_SHORT = 10;
`ifdef YIN_FEEDER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  yin_frame_feeder_if #(.DATA_WIDTH(DW), .WINDOW_LEN(N)) bus  ();
  yin_frame_feeder_if #(.DATA_WIDTH(DW), .WINDOW_LEN(N)) bus2 ();

  yin_frame_feeder #(
    .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(8), .MAX_TAU(40), .HOP(HOP),
    .TIMEOUT_CYCLES(65535)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  yin_frame_feeder #(
    .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(8), .MAX_TAU(40), .HOP(HOP),
    .TIMEOUT_CYCLES(TO_SHORT)
  ) dut_to (
    .clk(clk), .reset(rst2_n), .bus(bus2)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- stimulus driver (main DUT) ----------------
  bit          drv_en   = 1'b0;
  int unsigned density  = 100;
  bit          seq_mode = 1'b1;
  logic [7:0]  seq_val  = 8'd0;
  bit          m_fire   = 1'b0;

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    forever begin
      @(posedge clk); #1;
      if (!drv_en) begin
        bus.sample_valid = 1'b0;
      end else if (!bus.sample_valid || m_fire) begin
        if ($urandom_range(99) < density) begin
          bus.sample_valid = 1'b1;
          if (seq_mode) begin
            bus.sample_in = seq_val;
            seq_val++;
          end else begin
            bus.sample_in = 8'($urandom);
          end
        end else begin
          bus.sample_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [7:0]  tau;
    logic        to;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  win_q[$];       // last N samples that entered the window
  int unsigned target = N;
  int unsigned frame_acc = 0;
  bit          in_fill = 1'b1;
  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;
  bit          prev_er = 1'b1;
  bit          prev_pv = 1'b0;
  logic [7:0]  held_tau = 8'd0;
  int unsigned pub_count = 0;
  int unsigned exp_drop = 0;
  bit          first_checked = 1'b0;

  task automatic check_window();
    logic [N*DW-1:0] expv;
    int unsigned     sz;
    int              bad_slot;
    expv     = '0;
    sz       = win_q.size();
    bad_slot = -1;
    for (int unsigned i = 0; i < sz; i++) expv[(N - sz + i)*DW +: DW] = win_q[i];
    total++;
    if (bus.window !== expv) begin
      bad++;
      for (int unsigned j = 0; j < N; j++)
        if (bad_slot < 0 && bus.window[j*DW +: DW] !== expv[j*DW +: DW]) bad_slot = int'(j);
      if (bad_slot < 0) bad_slot = 0;
      $display("FAIL window slot %0d: actual=%0h required=%0h", bad_slot,
               bus.window[bad_slot*DW +: DW], expv[bad_slot*DW +: DW]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      win_q.delete();
      sb.delete();
      target    = N;
      frame_acc = 0;
      in_fill   = 1'b1;
      prev_er   = 1'b1;
      prev_pv   = 1'b0;
      held_tau  = 8'd0;
      exp_drop  = 0;
      m_fire    = 1'b0;
    end else begin
      check("sample_ready", bus.sample_ready, (in_fill || DROP) ? 1 : 0);
      m_fire = bus.sample_valid && bus.sample_ready;
      if (m_fire) begin
        if (in_fill) begin
          win_q.push_back(bus.sample_in);
          if (win_q.size() > N) void'(win_q.pop_front());
          frame_acc++;
          if (frame_acc == target) begin
            in_fill      = 1'b0;
            last_acc_cyc = cyc;
          end
        end else begin
          exp_drop++;
        end
      end

      if (prev_er && !bus.est_reset) begin
        check("kick_latency", cyc - last_acc_cyc, 2);
        check("accepts_per_frame", frame_acc, target);
      end
      prev_er = bus.est_reset;

      if (prev_pv) check("pitch_valid_pulse", bus.pitch_valid, 0);
      if (bus.pitch_valid) begin
        pub_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: actual=pitch_valid required=no_result_pending");
        end else begin
          e = sb.pop_front();
          check("pitch_tau", bus.pitch_tau, e.tau);
          check("timeout", bus.timeout, e.to);
          check("frame_count", bus.frame_count, e.fc);
          held_tau = e.tau;
        end
        check_window();
        if (!first_checked) begin
          check("first_slot0", bus.window[0 +: DW], 8'h00);
          check("first_slot295", bus.window[295*DW +: DW], 8'h27);
          first_checked = 1'b1;
        end
`ifdef YIN_FEEDER_DROP_EN
        check("drop_count", bus.drop_count, exp_drop);
`endif
        in_fill   = 1'b1;
        frame_acc = 0;
        target    = HOP;
      end else begin
        check("pitch_tau_hold", bus.pitch_tau, held_tau);
      end
      prev_pv = bus.pitch_valid;
    end
  end

  // ---------------- estimator model (main DUT) ----------------
  int unsigned wk = 0;
  int unsigned wd = 0;
  logic [7:0]  wtau = 8'd0;
  logic [15:0] exp_fc = 16'd0;
  bit          first_est = 1'b1;

  // est_ready is left at its last value outside WAIT, so a stale high level
  // is present during FILL and KICK of the next frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      wk     = 0;
      exp_fc = 16'd0;
    end else if (bus.est_reset) begin
      wk = 0;
    end else begin
      if (wk == 0) begin
        if (first_est) begin
          wd        = 50;
          wtau      = 8'd17;
          first_est = 1'b0;
        end else begin
          wd   = $urandom_range(1, 60);
          wtau = 8'($urandom_range(0, 255));
        end
      end
      wk++;
      if (wk == wd) begin
        bus.est_ready   = 1'b1;
        bus.est_min_tau = wtau;
        exp_fc++;
        sb.push_back('{tau: wtau, to: 1'b0, fc: exp_fc});
      end else begin
        bus.est_ready = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_pub(input int unsigned want, input int unsigned limit);
    int unsigned n = 0;
    while (pub_count < want && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("publish_arrived", pub_count, want);
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, "_window"}, 32'($countones(bus.window)), 0);
    check({tag, "_pitch_tau"}, bus.pitch_tau, 0);
    check({tag, "_pitch_valid"}, bus.pitch_valid, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_frame_count"}, bus.frame_count, 0);
    check({tag, "_est_reset"}, bus.est_reset, 1);
    check({tag, "_sample_ready"}, bus.sample_ready, 0);
`ifdef YIN_FEEDER_DROP_EN
    check({tag, "_drop_count"}, bus.drop_count, 0);
`endif
  endtask

  // One frame on the short-timeout DUT; returns the number of WAIT cycles.
  task automatic to_frame(input bit give_ready, output int unsigned waits);
    int unsigned n = 0;
    @(posedge clk); #1;
    bus2.sample_valid = 1'b1;
    @(negedge clk);
    while (bus2.est_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bus2.sample_valid = 1'b0;
    check("to_fill_done", bus2.est_reset, 0);
    waits = 0;
    while (!bus2.pitch_valid && waits < 50) begin
      if (!bus2.est_reset) waits++;
      if (give_ready && waits == TO_SHORT) begin
        bus2.est_ready   = 1'b1;
        bus2.est_min_tau = 8'd5;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned waits;
    int unsigned n;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus.est_ready     = 1'b0;
    bus.est_min_tau   = 8'd0;
    bus2.sample_valid = 1'b0;
    bus2.sample_in    = 8'h5A;
    bus2.est_ready    = 1'b0;
    bus2.est_min_tau  = 8'd0;
    drv_en   = 1'b1;
    density  = 100;
    seq_mode = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_main("rst");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // initial fill with 0..295, then one hop with valid held high
    wait_pub(1, 2000);
    wait_pub(2, 2000);

    // random values and gaps
    seq_mode = 1'b0;
    for (int unsigned f = 3; f <= 7; f++) begin
      density = $urandom_range(30, 100);
      wait_pub(f, 4000);
    end

    // reset in the middle of a fresh fill after 100 accepts
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    density = 100;
    n = 0;
    while (frame_acc < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midframe_accepts", (frame_acc >= 100) ? 1 : 0, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_main("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    density = 80;
    wait_pub(pub_count + 1, 4000);
    wait_pub(pub_count + 1, 4000);
    drv_en = 1'b0;

    // short-timeout instance: pure timeout, then ready on the expiry cycle
    @(posedge clk); #2;
    rst2_n = 1'b1;
    to_frame(1'b0, waits);
    check("to_wait_cycles", waits, TO_SHORT);
    check("to_pitch_valid", bus2.pitch_valid, 1);
    check("to_pitch_tau", bus2.pitch_tau, 0);
    check("to_timeout", bus2.timeout, 1);
    check("to_frame_count", bus2.frame_count, 1);
    to_frame(1'b1, waits);
    check("sim_wait_cycles", waits, TO_SHORT);
    check("sim_pitch_valid", bus2.pitch_valid, 1);
    check("sim_pitch_tau", bus2.pitch_tau, 5);
    check("sim_timeout", bus2.timeout, 0);
    check("sim_frame_count", bus2.frame_count, 2);
    bus2.est_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
